spi_inemo4: RTL and testbench



---
 rtl/inemo_pkg.sv | 9 +
 rtl/inemo_sync_edge.sv | 19 +
 rtl/spi_inemo4.sv | 109 ++++++++++
 tb/tb_spi_inemo4.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/inemo_pkg.sv
// inemo_pkg: register map constants shared by the iNEMO SPI-slave model
package inemo_pkg;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_YAW_L     = 7'h26;
  localparam logic [6:0] ADDR_YAW_H     = 7'h27;
  localparam logic [7:0] WHO_AM_I_VAL   = 8'h6A;
  localparam int         INT_EN_BIT     = 1;
endpackage

// File: rtl/inemo_sync_edge.sv
// inemo_sync_edge: 2-flop synchronizer with a third flop for rise/fall detection
module inemo_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], d};
  always_ff @(posedge clk) begin
    if (rst) s_q <= {3{RST_VAL}};
    else s_q <= s_d;
  end
  assign rise = s_q[1] & ~s_q[2];
  assign fall = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_inemo4.sv
// spi_inemo4: iNEMO SPI-slave yaw-rate sensor model; INEMO_SNAPSHOT_EN makes a YAW_L read latch YAW_H for the next YAW_H read
module spi_inemo4
  import inemo_pkg::*;
#(
  parameter int ODR_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] YAW
);
  localparam int OW = ODR_CYCLES > 1 ? $clog2(ODR_CYCLES) : 1;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_q, mosi_d;
  logic act_q, act_d;
  logic [4:0] cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [15:0] yaw_q, yaw_d;
  logic int_q, int_d;
  logic [OW-1:0] odr_q, odr_d;
  logic [6:0] addr;
  logic [7:0] rd_val, yaw_h_rd;
  logic wrap, cap, rise16, clr;
  inemo_sync_edge #(.RST_VAL(1'b1)) u_sclk (.clk(clk), .rst(rst), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall));
  inemo_sync_edge #(.RST_VAL(1'b1)) u_ss (.clk(clk), .rst(rst), .d(SS_n), .rise(ss_rise), .fall(ss_fall));
  assign addr = rx_q[14:8];
  always_comb begin
    mosi_d = {mosi_q[0], MOSI};
    wrap = odr_q == OW'(ODR_CYCLES - 1);
    odr_d = wrap ? '0 : odr_q + 1'b1;
    cap = wrap & ctrl_q[INT_EN_BIT];
    act_d = ss_fall ? 1'b1 : ss_rise ? 1'b0 : act_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    tx_d = tx_q;
    // rx fills by bit position so the command byte sits in rx[15:8] from rise #8 on
    if (ss_fall) begin
      cnt_d = '0;
      tx_d = '0;
      rx_d = '0;
    end else if (act_q && sclk_rise) begin
      rx_d[~cnt_q[3:0]] = mosi_q[1];
      cnt_d = cnt_q + 5'd1;
    end else if (act_q && sclk_fall) begin
      tx_d = (cnt_q == 5'd8 && rx_q[15]) ? rd_val : {tx_q[6:0], 1'b0};
    end
    rise16 = !ss_fall && act_q && sclk_rise && cnt_q == 5'd15;
    clr = rise16 && rx_q[15] && addr == ADDR_YAW_H;
    ctrl_d = (rise16 && !rx_q[15] && addr == ADDR_INT1_CTRL) ? rx_d[7:0] : ctrl_q;
    yaw_d = cap ? YAW : yaw_q;
    int_d = cap | (int_q & ~clr);
    rd_val = addr == ADDR_WHO_AM_I  ? WHO_AM_I_VAL :
             addr == ADDR_INT1_CTRL ? ctrl_q :
             addr == ADDR_YAW_L     ? yaw_q[7:0] :
             addr == ADDR_YAW_H     ? yaw_h_rd : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_q <= '0;
      act_q <= 1'b0;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      ctrl_q <= '0;
      yaw_q <= '0;
      int_q <= 1'b0;
      odr_q <= '0;
    end else begin
      mosi_q <= mosi_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      ctrl_q <= ctrl_d;
      yaw_q <= yaw_d;
      int_q <= int_d;
      odr_q <= odr_d;
    end
  end
`ifdef INEMO_SNAPSHOT_EN
  logic [7:0] shd_q, shd_d;
  logic shv_q, shv_d, ld;
  always_comb begin
    ld = !ss_fall && act_q && sclk_fall && cnt_q == 5'd8 && rx_q[15];
    shd_d = (ld && addr == ADDR_YAW_L) ? yaw_q[15:8] : shd_q;
    shv_d = (ld && addr == ADDR_YAW_L) ? 1'b1 : (ld && addr == ADDR_YAW_H) ? 1'b0 : shv_q;
    yaw_h_rd = shv_q ? shd_q : yaw_q[15:8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_q <= '0;
      shv_q <= 1'b0;
    end else begin
      shd_q <= shd_d;
      shv_q <= shv_d;
    end
  end
`else
  always_comb yaw_h_rd = yaw_q[15:8];
`endif
  assign MISO = SS_n ? 1'bz : tx_q[7];
  assign INT = int_q;
endmodule

// File: tb/tb_spi_inemo4.sv
// tb_spi_inemo4: scoreboard bench driving SPI frames and checking MISO read bytes and INT behaviour
module tb_spi_inemo4;
  localparam int ODR = 1024;
  localparam int H = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n = 1'b1;
  logic SCLK = 1'b1;
  logic MOSI = 1'b0;
  logic [15:0] YAW = 16'h0000;
  logic MISO, INT;
  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  string name_q[$];

  spi_inemo4 #(.ODR_CYCLES(ODR)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .YAW(YAW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic spi(input logic [15:0] w, input int n, input bit chk_clr);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      repeat (H) @(negedge clk);
      SCLK = 1'b1;
      if (chk_clr && i == 15) begin
        repeat (2) @(negedge clk);
        chk("int_held_before_clear", {15'b0, INT}, 16'd1);
        @(negedge clk);
        chk("int_cleared_after_rise16", {15'b0, INT}, 16'd0);
        repeat (H - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] e, input string nm, input bit chk_clr);
    exp_q.push_back({1'b1, e});
    name_q.push_back(nm);
    spi({1'b1, a, 8'h00}, 16, chk_clr);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back(9'h000);
    name_q.push_back("write");
    spi({1'b0, a, d}, 16, 1'b0);
  endtask

  task automatic wait_int(input string nm);
    for (int k = 0; k < ODR + 4; k++) begin
      @(negedge clk);
      if (INT === 1'b1) break;
    end
    chk(nm, {15'b0, INT}, 16'd1);
  endtask

  initial begin : monitor
    logic [15:0] w;
    logic [8:0] e;
    string nm;
    int n;
    forever begin
      @(negedge SS_n);
      n = 0;
      w = '0;
      forever begin
        @(posedge SCLK or posedge SS_n);
        if (SS_n) break;
        w = {w[14:0], MISO};
        n++;
      end
      if (n == 16) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h expected no frame", w);
        end else begin
          e = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[8]) chk(nm, {8'h00, w[7:0]}, {8'h00, e[7:0]});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_int", {15'b0, INT}, 16'd0);
    checks++;
    if (MISO !== 1'bz) begin
      errors++;
      $display("FAIL reset_miso: got %b expected z", MISO);
    end
    rd(7'h0F, 8'h6A, "who_am_i", 1'b0);
    chk("who_int_low", {15'b0, INT}, 16'd0);
    repeat (3 * ODR) @(negedge clk);
    chk("no_enable_int_low", {15'b0, INT}, 16'd0);
    rd(7'h27, 8'h00, "yaw_h_disabled", 1'b0);
    YAW = 16'h1234;
    wr(7'h0D, 8'h02);
    wait_int("int_after_enable");
    rd(7'h26, 8'h34, "yaw_l_1234", 1'b0);
    chk("int_kept_after_yaw_l", {15'b0, INT}, 16'd1);
    rd(7'h27, 8'h12, "yaw_h_1234", 1'b1);
    wait_int("int_before_abort");
    spi(16'hA700, 10, 1'b0);
    chk("int_after_abort", {15'b0, INT}, 16'd1);
    rd(7'h0F, 8'h6A, "who_after_abort", 1'b0);
    rd(7'h27, 8'h12, "yaw_h_clear", 1'b0);
    YAW = 16'hFF80;
    wait_int("int_ff80");
    rd(7'h26, 8'h80, "yaw_l_ff80", 1'b0);
    rd(7'h27, 8'hFF, "yaw_h_ff80", 1'b0);
    rd(7'h26, 8'h80, "yaw_l_ff80_again", 1'b0);
    YAW = 16'h0001;
    wait_int("int_0001");
`ifdef INEMO_SNAPSHOT_EN
    rd(7'h27, 8'hFF, "yaw_h_snapshot", 1'b0);
`else
    rd(7'h27, 8'h00, "yaw_h_live", 1'b0);
`endif
    rd(7'h26, 8'h01, "yaw_l_0001", 1'b0);
    wait_int("int_before_reset");
    rd(7'h0D, 8'h02, "ctrl_before_reset", 1'b0);
    fork
      spi(16'hA700, 5, 1'b0);
      begin
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    chk("int_after_reset", {15'b0, INT}, 16'd0);
    rd(7'h0D, 8'h00, "ctrl_after_reset", 1'b0);
    wr(7'h10, 8'hAB);
    rd(7'h10, 8'h00, "unmapped_read", 1'b0);
    repeat (ODR + 4) @(negedge clk);
    chk("int_stays_low_after_reset", {15'b0, INT}, 16'd0);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
